// File: rtl/pipelined_adder_chk.sv
// rtl/pipelined_adder_chk.sv - pipelined chunked-carry adder with shadow-sum self-check
//
// Purpose:
//   WIDTH-bit adder (a + b + cin) whose carry chain is split into STAGES equal
//   chunks, one chunk per pipeline stage. Operands of higher chunks are carried
//   down the pipe so each chunk meets the carry of the same transaction. A shadow
//   golden sum travels alongside every transaction and is compared with the
//   assembled result when it is handed off.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   a, b, cin             operands and carry in
//   out_valid / out_ready result handshake
//   sum, cout             registered result and carry out of the MSB
//   txn_cnt               results handed off, wraps
//   err_cnt               mismatching results handed off, saturates
//   err_sticky            set on first mismatch, cleared only by reset
//
// Configuration:
//   PIPELINED_ADDER_CHK_ASSERT_EN - when defined, adds immediate final assertions
//   on handoff result, operand known-ness and the in_ready relation.

module pipelined_adder_chk #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    // Per-stage state: valid, chunk carry-out, skewed operands, partial sum, shadow sum.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a    [STAGES];
    logic [WIDTH-1:0]  r_b    [STAGES];
    logic [WIDTH-1:0]  r_sum  [STAGES];
    logic [WIDTH:0]    r_gold [STAGES];

    logic [CNT_W-1:0]  r_txn_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_err_sticky;

    logic [C:0]        w_chunk [STAGES];
    logic [WIDTH-1:0]  w_sum   [STAGES];
    logic              w_c0_nxt;
    logic              w_adv;
    logic              w_hand;
    logic              w_mis;
    logic [WIDTH:0]    w_gold_in;

    // Chunk k is added in stage k: stage 0 uses the live operands and cin,
    // later stages use the operands delayed alongside the transaction and the
    // carry registered by the previous stage.
    always_comb begin
        w_chunk[0]        = {1'b0, a[C-1:0]} + {1'b0, b[C-1:0]} + {{C{1'b0}}, cin};
        w_sum[0]          = '0;
        w_sum[0][C-1:0]   = w_chunk[0][C-1:0];
        for (int k = 1; k < STAGES; k++) begin
            w_chunk[k]          = {1'b0, r_a[k-1][k*C +: C]} + {1'b0, r_b[k-1][k*C +: C]}
                                + {{C{1'b0}}, r_c[k-1]};
            w_sum[k]            = r_sum[k-1];
            w_sum[k][k*C +: C]  = w_chunk[k][C-1:0];
        end
    end

    assign w_c0_nxt  = w_chunk[0][C];
    assign w_gold_in = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign w_adv  = !r_vld[L] || out_ready;
    assign w_hand = r_vld[L] && out_ready;
    assign w_mis  = {r_c[L], r_sum[L]} != r_gold[L];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_c   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_sum[k]  <= '0;
                r_gold[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0]  <= in_valid;
            r_c[0]    <= w_c0_nxt;
            r_a[0]    <= a;
            r_b[0]    <= b;
            r_sum[0]  <= w_sum[0];
            r_gold[0] <= w_gold_in;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_c[k]    <= w_chunk[k][C];
                r_a[k]    <= r_a[k-1];
                r_b[k]    <= r_b[k-1];
                r_sum[k]  <= w_sum[k];
                r_gold[k] <= r_gold[k-1];
            end
        end
    end

    // Handoff bookkeeping: txn_cnt wraps, err_cnt sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_cnt    <= '0;
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_hand) begin
            r_txn_cnt <= r_txn_cnt + 1'b1;
            if (w_mis) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready   = w_adv;
    assign out_valid  = r_vld[L];
    assign sum        = r_sum[L];
    assign cout       = r_c[L];
    assign txn_cnt    = r_txn_cnt;
    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;

`ifdef PIPELINED_ADDER_CHK_ASSERT_EN
    always_comb begin
        if (rst_n && w_hand) begin
            assert final ({r_c[L], r_sum[L]} == r_gold[L])
                $info("pipelined_adder_chk: result ok at %0t", $time);
            else
                $error("pipelined_adder_chk: result differs from shadow sum at %0t", $time);
        end
        if (rst_n && in_valid && in_ready) begin
            assert final (!$isunknown({a, b, cin}))
            else
                $error("pipelined_adder_chk: unknown operands accepted at %0t", $time);
        end
        if (rst_n) begin
            assert final (in_ready == (!out_valid || out_ready))
            else
                $error("pipelined_adder_chk: in_ready relation broken at %0t", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_pipelined_adder_chk.sv
// tb/tb_pipelined_adder_chk.sv - self-checking bench for pipelined_adder_chk

module tb_pipelined_adder_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, err_sticky;
    logic [7:0]  a, b, sum;
    logic [2:0]  txn_cnt, err_cnt;

    logic        s1_in_ready, s1_out_valid, s1_cout, s1_sticky;
    logic [7:0]  s1_sum;
    logic [15:0] s1_txn, s1_err;

    logic        w4_in_valid, w4_in_ready, w4_cin, w4_out_valid, w4_out_ready, w4_cout, w4_sticky;
    logic [3:0]  w4_a, w4_b, w4_sum;
    logic [15:0] w4_txn, w4_err;

    pipelined_adder_chk #(.WIDTH(8), .STAGES(2), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .txn_cnt(txn_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    pipelined_adder_chk #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(s1_out_valid), .out_ready(1'b1),
        .sum(s1_sum), .cout(s1_cout), .txn_cnt(s1_txn), .err_cnt(s1_err), .err_sticky(s1_sticky)
    );

    pipelined_adder_chk #(.WIDTH(4), .STAGES(2), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .cin(w4_cin), .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .sum(w4_sum), .cout(w4_cout), .txn_cnt(w4_txn), .err_cnt(w4_err), .err_sticky(w4_sticky)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8:0] gold8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'b0, c};
    endfunction

    // Result when the carry between the low and high nibble is lost.
    function automatic logic [8:0] nocarry8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [4:0] lo, hi;
        lo = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, c};
        hi = {1'b0, x[7:4]} + {1'b0, y[7:4]};
        return {hi, lo[3:0]};
    endfunction

    // Reference model for the main instance: FIFO of expected results in acceptance order.
    logic [8:0] q_exp[$];
    logic [8:0] q_gold[$];
    int         m_txn = 0;
    int         m_err = 0;
    logic       m_sticky = 1'b0;
    logic       inj = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] held;

    always @(negedge clk) begin
        logic [8:0] e, g;
        if (!rst_n) begin
            q_exp.delete();
            q_gold.delete();
            m_txn = 0;
            m_err = 0;
            m_sticky = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rel", in_ready, !out_valid || out_ready);
            chk("txn_cnt", txn_cnt, m_txn % 8);
            chk("err_cnt", err_cnt, m_err);
            chk("err_sticky", err_sticky, m_sticky);
            if (prev_stall) chk("stall_hold", {out_valid, cout, sum}, {1'b1, held});
            if (out_valid && out_ready) begin
                chk("out_has_txn", q_exp.size() != 0, 1);
                if (q_exp.size() != 0) begin
                    e = q_exp.pop_front();
                    g = q_gold.pop_front();
                    chk("result", {cout, sum}, e);
                    m_txn++;
                    if (e != g) begin
                        m_sticky = 1'b1;
                        if (m_err < 7) m_err++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                g = gold8(a, b, cin);
                q_gold.push_back(g);
                q_exp.push_back(inj ? nocarry8(a, b, cin) : g);
            end
            prev_stall = out_valid && !out_ready;
            held = {cout, sum};
        end
    end

    // Single-stage instance: always ready, result one cycle after the operands.
    logic       p1_v = 1'b0;
    logic [8:0] p1_g;
    always @(negedge clk) begin
        if (!rst_n) begin
            p1_v = 1'b0;
        end else begin
            chk("s1_valid", s1_out_valid, p1_v);
            if (p1_v) chk("s1_result", {s1_cout, s1_sum}, p1_g);
            p1_v = in_valid;
            p1_g = gold8(a, b, cin);
        end
    end

    // 4-bit instance model.
    logic [4:0] q4[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            q4.delete();
        end else begin
            if (w4_out_valid && w4_out_ready) begin
                chk("w4_has_txn", q4.size() != 0, 1);
                if (q4.size() != 0) chk("w4_result", {w4_cout, w4_sum}, q4.pop_front());
            end
            if (w4_in_valid && w4_in_ready)
                q4.push_back({1'b0, w4_a} + {1'b0, w4_b} + {4'b0, w4_cin});
        end
    end

    task automatic single(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [7:0] es, input logic ec);
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_sum", sum, es);
        chk("lat_cout", cout, ec);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {out_valid, cout, sum}, 10'h000);
        chk("rst_cnt", {txn_cnt, err_cnt, err_sticky}, 7'h00);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_cnt", {txn_cnt, err_cnt, err_sticky}, 7'h00);
        end
        @(posedge clk); #1;

        // Single transactions with hand-computed results.
        single(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("single_txn", txn_cnt, 1);
        chk("single_err", err_cnt, 0);
        @(posedge clk); #1;
        single(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        @(negedge clk);
        chk("ones_txn", txn_cnt, 2);
        @(posedge clk); #1;

        // Backpressure with a full pipe.
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out", {out_valid, cout, sum}, {1'b1, 9'h047});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        chk("bp_accept", acc, 1);
        drain();

        // Randomised traffic with random backpressure and bubbles.
        acc = 1'b1;
        repeat (400) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        drain();

        // Reset with two transactions in flight.
        a = 8'h21; b = 8'h43; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h05; b = 8'h06;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid, cout, sum}, 10'h000);
        chk("mid_rst_cnt", {txn_cnt, err_cnt, err_sticky}, 7'h00);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        single(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        @(negedge clk);
        chk("post_rst_txn", txn_cnt, 1);
        @(posedge clk); #1;
        drain();

        // Error injection: drop the stage-0 carry for one transaction.
        force dut.w_c0_nxt = 1'b0;
        inj = 1'b1;
        a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        release dut.w_c0_nxt;
        inj = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("inj_out", {out_valid, cout, sum}, {1'b1, 9'h000});
        @(negedge clk);
        chk("inj_err", err_cnt, 1);
        chk("inj_sticky", err_sticky, 1);
        @(posedge clk); #1;

        // Eight more injected errors: err_cnt saturates, txn_cnt keeps counting.
        force dut.w_c0_nxt = 1'b0;
        inj = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = {4'($urandom), 4'hF};
            b = {4'($urandom), 4'h1};
            cin = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        release dut.w_c0_nxt;
        inj = 1'b0;
        drain();
        @(negedge clk);
        chk("sat_err", err_cnt, 7);
        chk("sat_sticky", err_sticky, 1);
        @(posedge clk); #1;

        // Exhaustive 4-bit sweep, back-to-back.
        for (int i = 0; i < 512; i++) begin
            {w4_a, w4_b, w4_cin} = 9'(i);
            w4_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        w4_in_valid = 1'b0;
        @(negedge clk);
        chk("w4_txn_stream", w4_txn, 510);
        @(negedge clk);
        @(negedge clk);
        chk("w4_txn_total", w4_txn, 512);
        chk("w4_err", w4_err, 0);
        chk("w4_idle", w4_out_valid, 0);
        chk("s1_err", s1_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
